// File: rtl/shifter_rotator_32.sv
// shifter_rotator_32
//   Registered 32-bit shift/rotate unit for the execute stage. A five-stage
//   barrel network shifts or rotates operand `a` by `bits`. The result is
//   captured in an output register, so it appears one clock after the inputs
//   are sampled.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; clears out
//   a      in   [WIDTH-1:0] operand
//   op     in   [1:0] 00 srl, 01 sll, 10 ror, 11 rol
//   bits   in   [SHAMT_W-1:0] shift/rotate amount
//   out    out  [WIDTH-1:0] registered result
module shifter_rotator_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] bits,
  output logic [WIDTH-1:0]   out
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // stg[0] is the operand. stg[k+1] is the output of the stage that moves
  // the data by 2^k positions.
  logic [SHAMT_W:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0]            out_d;
  logic [WIDTH-1:0]            out_q;

  assign stg[0] = a;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int N = 1 << k;

    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] moved;

    assign srl_v = stg[k] >> N;
    assign sll_v = stg[k] << N;

    // A rotate is the matching logical shift ORed with the bits that fall
    // off the far end, which are brought back in from the opposite side.
    always_comb begin
      moved = srl_v;
      case (op)
        OP_SRL:  moved = srl_v;
        OP_SLL:  moved = sll_v;
        OP_ROR:  moved = srl_v | (stg[k] << (WIDTH - N));
        OP_ROL:  moved = sll_v | (stg[k] >> (WIDTH - N));
        default: moved = srl_v;
      endcase
    end

    assign stg[k+1] = bits[k] ? moved : stg[k];
  end

  always_comb begin
    out_d = stg[SHAMT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_shifter_rotator_32.sv
module tb_shifter_rotator_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [1:0]  op;
  logic [4:0]  bits;
  logic [31:0] dut_out;

  int checks = 0;
  int errors = 0;

  shifter_rotator_32 #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .op    (op),
    .bits  (bits),
    .out   (dut_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: each result bit is picked from its source position in `a`.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [1:0] opv,
                                        input int n);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (opv)
        2'b00: begin src = i + n; if (src < 32) r[i] = av[src]; end
        2'b01: begin src = i - n; if (src >= 0) r[i] = av[src]; end
        2'b10: r[i] = av[(i + n) % 32];
        default: r[i] = av[(i - n + 32) % 32];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic [31:0] av, input logic [1:0] opv, input logic [4:0] bv);
    a    = av;
    op   = opv;
    bits = bv;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(32'hC000_0003, 2'b01, 5'd8);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: out=%h expected=%h", dut_out, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_held: out=%h expected=%h", dut_out, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_no_edge: out=%h expected=%h", dut_out, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 32'h0000_0300) begin
      errors++;
      $display("FAIL reset_first_result: out=%h expected=%h", dut_out, 32'h0000_0300);
    end
  endtask

  typedef struct packed {
    logic [31:0] av;
    logic [1:0]  opv;
    logic [4:0]  bv;
    logic [31:0] ev;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    v[0]  = '{32'hF0F0_F0FF, 2'b10, 5'd0,  32'hF0F0_F0FF};
    v[1]  = '{32'hF0F0_F0F0, 2'b11, 5'd15, 32'h7878_7878};
    v[2]  = '{32'hC000_0003, 2'b00, 5'd16, 32'h0000_C000};
    v[3]  = '{32'hC000_0003, 2'b00, 5'd31, 32'h0000_0001};
    v[4]  = '{32'hC000_0003, 2'b00, 5'd1,  32'h6000_0001};
    v[5]  = '{32'hC000_0003, 2'b01, 5'd8,  32'h0000_0300};
    v[6]  = '{32'hC000_0003, 2'b01, 5'd31, 32'h8000_0000};
    v[7]  = '{32'h1FFF_FFFF, 2'b01, 5'd6,  32'hFFFF_FFC0};
    v[8]  = '{32'hC000_0003, 2'b11, 5'd1,  32'h8000_0007};
    v[9]  = '{32'hC000_0003, 2'b10, 5'd4,  32'h3C00_0000};
    v[10] = '{32'hC000_0003, 2'b10, 5'd31, 32'h8000_0007};
    v[11] = '{32'hA5A5_1234, 2'b00, 5'd0,  32'hA5A5_1234};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v[i].av, v[i].opv, v[i].bv);
      @(posedge clk);
      #1;
      checks++;
      if (dut_out !== v[i].ev) begin
        errors++;
        $display("FAIL directed_%0d: a=%h op=%b bits=%0d out=%h expected=%h",
                 i, v[i].av, v[i].opv, v[i].bv, dut_out, v[i].ev);
      end
    end
  endtask

  // Zero amount must pass the operand through for every op.
  task automatic test_zero_amount();
    logic [31:0] av;
    for (int o = 0; o < 4; o++) begin
      av = $urandom;
      @(negedge clk);
      drive(av, 2'(o), 5'd0);
      @(posedge clk);
      #1;
      checks++;
      if (dut_out !== av) begin
        errors++;
        $display("FAIL zero_amount op=%0d: out=%h expected=%h", o, dut_out, av);
      end
    end
  endtask

  // A new operation every cycle; each result is checked one edge later.
  task automatic test_back_to_back();
    logic [31:0] av;
    logic [1:0]  opv;
    logic [4:0]  bv;
    logic [31:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      av  = $urandom;
      opv = 2'($urandom_range(0, 3));
      bv  = 5'($urandom_range(0, 31));
      exp_v = model(av, opv, int'(bv));
      @(negedge clk);
      drive(av, opv, bv);
      @(posedge clk);
      #1;
      checks++;
      if (dut_out !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: a=%h op=%b bits=%0d out=%h expected=%h",
                 i, av, opv, bv, dut_out, exp_v);
      end
      if (opv[1]) begin
        checks++;
        if ($countones(dut_out) != $countones(av)) begin
          errors++;
          $display("FAIL rotate_popcount_%0d: out ones=%0d expected=%0d",
                   i, $countones(dut_out), $countones(av));
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] first_v;
    first_v = model(32'h1234_5678, 2'b11, 7);
    @(negedge clk);
    drive(32'h1234_5678, 2'b11, 5'd7);
    @(posedge clk);
    #1;
    drive(32'hDEAD_BEEF, 2'b00, 5'd3);
    #3;
    checks++;
    if (dut_out !== first_v) begin
      errors++;
      $display("FAIL hold_midcycle: out=%h expected=%h", dut_out, first_v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 32'h1BD5_B7DD) begin
      errors++;
      $display("FAIL hold_next_edge: out=%h expected=%h", dut_out, 32'h1BD5_B7DD);
    end
  endtask

  task automatic test_midop_reset();
    logic [31:0] exp_v;
    @(negedge clk);
    drive(32'hC000_0003, 2'b10, 5'd4);
    @(posedge clk);
    #1;
    drive(32'hFFFF_0000, 2'b01, 5'd4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset_async: out=%h expected=%h", dut_out, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset_held: out=%h expected=%h", dut_out, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = model(32'hFFFF_0000, 2'b01, 4);
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== exp_v) begin
      errors++;
      $display("FAIL midop_reset_release: out=%h expected=%h", dut_out, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    a     = '0;
    op    = '0;
    bits  = '0;
    test_reset();
    test_directed();
    test_zero_amount();
    test_back_to_back();
    test_hold();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
